counter_down_load: RTL and testbench

- Loadable down-counter and timer. It is the counterpart to the team's up-counter with enable.
- Software or control logic loads a start value, and the block counts it down under count_enb.
- It flags terminal count with a one-cycle pulse, in either one-shot or periodic (auto-reload) mode.
- Used as an interval and timeout generator in the datapath.

---
 rtl/counter_down_load_if.sv | 25 ++
 rtl/counter_down_load.sv | 114 +++++++++++
 tb/tb_counter_down_load.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/counter_down_load_if.sv
// Control/status bundle for counter_down_load: the master loads and gates the
// timer, the slave (the counter) returns its value and event pulses.
interface counter_down_load_if #(
  parameter int N = 7
);
  logic         count_enb;
  logic         load;
  logic [N-1:0] load_val;
  logic         periodic;
  logic         abort;
  logic [N-1:0] count;
  logic         busy;
  logic         tc;
  logic         load_ack;

  modport master (
    output count_enb, load, load_val, periodic, abort,
    input  count, busy, tc, load_ack
  );

  modport slave (
    input  count_enb, load, load_val, periodic, abort,
    output count, busy, tc, load_ack
  );
endinterface

// File: rtl/counter_down_load.sv
// Loadable down-counter / interval timer with one-shot and auto-reload modes.
// Define COUNTER_DOWN_PRESCALE_EN to divide the decrement rate by PRESC.
//
// state  | meaning
// S_IDLE | parked, count at 0, waiting for a nonzero load
// S_RUN  | counting down on enabled ticks, busy high
// S_DONE | one-shot expired, one cycle before returning to idle
module counter_down_load #(
  parameter int N     = 7,
  parameter int PRESC = 4
) (
  input logic                clk,
  input logic                reset,
  counter_down_load_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // A divide ratio below 2 is not a legal configuration; the counter stalls.
  localparam bit PRESC_LEGAL = (PRESC >= 2);

  state_t       state_q;
  logic [N-1:0] count_q;
  logic [N-1:0] reload_q;
  logic         busy_q;
  logic         tc_q;
  logic         load_ack_q;
  logic         load_ok_d;
  logic         step_d;

  assign load_ok_d = bus.load && (bus.load_val != '0);

`ifdef COUNTER_DOWN_PRESCALE_EN
  localparam int PW = (PRESC > 2) ? $clog2(PRESC) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESC - 1);

  logic [PW-1:0] presc_q;

  assign step_d = PRESC_LEGAL && bus.count_enb && (presc_q == PRESC_LAST);

  // Counts enabled cycles only while running; any restart or exit re-phases it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc_q <= '0;
    end else if (bus.abort || load_ok_d || (state_q != S_RUN)) begin
      presc_q <= '0;
    end else if (bus.count_enb) begin
      presc_q <= (presc_q == PRESC_LAST) ? '0 : presc_q + 1'b1;
    end
  end
`else
  assign step_d = PRESC_LEGAL && bus.count_enb;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      count_q    <= '0;
      reload_q   <= '0;
      busy_q     <= 1'b0;
      tc_q       <= 1'b0;
      load_ack_q <= 1'b0;
    end else begin
      tc_q       <= 1'b0;
      load_ack_q <= 1'b0;
      if (bus.abort) begin
        state_q <= S_IDLE;
        count_q <= '0;
        busy_q  <= 1'b0;
      end else if (load_ok_d) begin
        // A restart wins over a terminal count due in the same cycle.
        state_q    <= S_RUN;
        count_q    <= bus.load_val;
        reload_q   <= bus.load_val;
        busy_q     <= 1'b1;
        load_ack_q <= 1'b1;
      end else begin
        unique case (state_q)
          S_RUN: begin
            if (step_d) begin
              if (count_q > N'(1)) begin
                count_q <= count_q - 1'b1;
              end else if (bus.periodic) begin
                count_q <= reload_q;
                tc_q    <= 1'b1;
              end else begin
                count_q <= '0;
                tc_q    <= 1'b1;
                busy_q  <= 1'b0;
                state_q <= S_DONE;
              end
            end
          end
          S_DONE: begin
            state_q <= S_IDLE;
          end
          default: begin
            state_q <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign bus.count    = count_q;
  assign bus.busy     = busy_q;
  assign bus.tc       = tc_q;
  assign bus.load_ack = load_ack_q;

endmodule

// File: tb/tb_counter_down_load.sv
// Self-checking bench for counter_down_load: fixed vector table, hand-written
// corner sequences and a randomized run against a behavioural model.
module tb_counter_down_load;
  localparam int N     = 7;
  localparam int PRESC = 4;
`ifdef COUNTER_DOWN_PRESCALE_EN
  localparam int P = PRESC;
`else
  localparam int P = 1;
`endif

  logic clk;
  logic reset;

  counter_down_load_if #(.N(N)) cif ();

  counter_down_load #(.N(N), .PRESC(PRESC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (cif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Model: mode 0 idle, 1 running, 2 expired; pre counts enabled cycles modulo P.
  int m_mode, m_cnt, m_rel, m_pre;
  bit m_tc, m_ack;

  function void model_reset();
    m_mode = 0; m_cnt = 0; m_rel = 0; m_pre = 0; m_tc = 0; m_ack = 0;
  endfunction

  function void model_step();
    int lv;
    lv    = int'(cif.load_val);
    m_tc  = 0;
    m_ack = 0;
    if (cif.abort) begin
      m_mode = 0; m_cnt = 0; m_pre = 0;
    end else if (cif.load && lv != 0) begin
      m_mode = 1; m_cnt = lv; m_rel = lv; m_ack = 1; m_pre = 0;
    end else if (m_mode == 1) begin
      if (cif.count_enb) begin
        if (m_pre == P - 1) begin
          m_pre = 0;
          if (m_cnt > 1) m_cnt = m_cnt - 1;
          else begin
            m_tc = 1;
            if (cif.periodic) m_cnt = m_rel;
            else begin m_cnt = 0; m_mode = 2; end
          end
        end else m_pre = m_pre + 1;
      end
    end else begin
      m_mode = 0; m_pre = 0;
    end
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input bit ld, input int lv, input bit en, input bit per, input bit ab);
    cif.load      = ld;
    cif.load_val  = N'(lv);
    cif.count_enb = en;
    cif.periodic  = per;
    cif.abort     = ab;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".count"}, int'(cif.count), m_cnt);
    chk({tag, ".busy"}, int'(cif.busy), (m_mode == 1) ? 1 : 0);
    chk({tag, ".tc"}, int'(cif.tc), int'(m_tc));
    chk({tag, ".ack"}, int'(cif.load_ack), int'(m_ack));
  endtask

  typedef struct {
    bit ld; int lv; bit en; bit per; bit ab;
    int e_cnt; bit e_busy; bit e_tc; bit e_ack;
  } vec_t;

  vec_t vecs[$];

  function void add(bit ld, int lv, bit en, bit per, bit ab,
                    int e_cnt, bit e_busy, bit e_tc, bit e_ack);
    vec_t v;
    v.ld = ld; v.lv = lv; v.en = en; v.per = per; v.ab = ab;
    v.e_cnt = e_cnt; v.e_busy = e_busy; v.e_tc = e_tc; v.e_ack = e_ack;
    vecs.push_back(v);
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int bound;
    //   ld lv  en per ab   cnt busy tc ack
    add(1,  5, 1, 0, 0,   5, 1, 0, 1);
    add(0,  0, 1, 0, 0,   4, 1, 0, 0);
    add(0,  0, 1, 0, 0,   3, 1, 0, 0);
    add(0,  0, 1, 0, 0,   2, 1, 0, 0);
    add(0,  0, 1, 0, 0,   1, 1, 0, 0);
    add(0,  0, 1, 0, 0,   0, 0, 1, 0);
    add(0,  0, 1, 0, 0,   0, 0, 0, 0);
    add(1,  0, 1, 0, 0,   0, 0, 0, 0);
    add(1,  1, 1, 0, 0,   1, 1, 0, 1);
    add(0,  0, 1, 0, 0,   0, 0, 1, 0);
    add(1,  3, 1, 1, 0,   3, 1, 0, 1);
    add(0,  0, 1, 1, 0,   2, 1, 0, 0);
    add(0,  0, 0, 1, 0,   2, 1, 0, 0);
    add(0,  0, 1, 1, 0,   1, 1, 0, 0);
    add(0,  0, 0, 1, 0,   1, 1, 0, 0);
    add(0,  0, 1, 1, 0,   3, 1, 1, 0);
    add(0,  0, 0, 1, 0,   3, 1, 0, 0);
    add(0,  0, 1, 1, 0,   2, 1, 0, 0);
    add(0,  0, 1, 0, 0,   1, 1, 0, 0);
    add(0,  0, 1, 0, 0,   0, 0, 1, 0);
    add(0,  0, 0, 0, 0,   0, 0, 0, 0);
    add(1, 20, 1, 0, 0,  20, 1, 0, 1);
    add(0,  0, 1, 0, 0,  19, 1, 0, 0);
    add(0,  0, 1, 0, 0,  18, 1, 0, 0);
    add(0,  0, 1, 0, 0,  17, 1, 0, 0);
    add(0,  0, 1, 0, 0,  16, 1, 0, 0);
    add(1,  7, 1, 0, 0,   7, 1, 0, 1);
    add(1,  0, 1, 0, 0,   6, 1, 0, 0);
    add(1,  9, 1, 0, 1,   0, 0, 0, 0);
    add(0,  0, 1, 0, 0,   0, 0, 0, 0);
    add(1,  2, 1, 0, 0,   2, 1, 0, 1);
    add(0,  0, 1, 0, 0,   1, 1, 0, 0);
    add(1,  4, 1, 0, 0,   4, 1, 0, 1);
    add(0,  0, 1, 0, 1,   0, 0, 0, 0);
    add(0,  0, 1, 0, 1,   0, 0, 0, 0);
    add(1,  1, 1, 1, 0,   1, 1, 0, 1);
    add(0,  0, 1, 1, 0,   1, 1, 1, 0);
    add(0,  0, 1, 1, 0,   1, 1, 1, 0);
    add(0,  0, 1, 0, 1,   0, 0, 0, 0);

    reset = 1'b0;
    drive(0, 0, 0, 0, 0);
    #12;
    chk("reset.count", int'(cif.count), 0);
    chk("reset.busy", int'(cif.busy), 0);
    chk("reset.tc", int'(cif.tc), 0);
    chk("reset.ack", int'(cif.load_ack), 0);
    model_reset();
    reset = 1'b1;

`ifndef COUNTER_DOWN_PRESCALE_EN
    foreach (vecs[i]) begin
      drive(vecs[i].ld, vecs[i].lv, vecs[i].en, vecs[i].per, vecs[i].ab);
      cycle();
      chk($sformatf("vec%0d.count", i), int'(cif.count), vecs[i].e_cnt);
      chk($sformatf("vec%0d.busy", i), int'(cif.busy), int'(vecs[i].e_busy));
      chk($sformatf("vec%0d.tc", i), int'(cif.tc), int'(vecs[i].e_tc));
      chk($sformatf("vec%0d.ack", i), int'(cif.load_ack), int'(vecs[i].e_ack));
    end
`endif

    // Asynchronous reset in the middle of a run, away from any clock edge.
    drive(1, 10, 1, 0, 0);
    cycle();
    drive(0, 0, 1, 0, 0);
    repeat (3) cycle();
    chk("midrun.count_before", int'(cif.count), (P == 1) ? 7 : 10);
    #3;
    reset = 1'b0;
    #1;
    chk("midrun.count", int'(cif.count), 0);
    chk("midrun.busy", int'(cif.busy), 0);
    chk("midrun.tc", int'(cif.tc), 0);
    chk("midrun.ack", int'(cif.load_ack), 0);
    model_reset();
    #1;
    reset = 1'b1;

    // Full-scale load: terminal count after 127 enabled steps.
    drive(1, 127, 1, 0, 0);
    cycle();
    chk("max.ack", int'(cif.load_ack), 1);
    drive(0, 0, 1, 0, 0);
    bound = 127 * P + 20;
    n = 0;
    while (n < bound) begin
      cycle();
      n++;
      if (cif.tc) break;
    end
    chk("max.tc_latency", n, 127 * P);
    chk("max.count_at_tc", int'(cif.count), 0);
    cycle();

`ifdef COUNTER_DOWN_PRESCALE_EN
    drive(1, 2, 1, 0, 0);
    cycle();
    chk("presc.ack", int'(cif.load_ack), 1);
    drive(0, 0, 1, 0, 0);
    repeat (PRESC - 1) cycle();
    chk("presc.count_hold", int'(cif.count), 2);
    cycle();
    chk("presc.count_step", int'(cif.count), 1);
    n = PRESC;
    while (n < 4 * PRESC) begin
      cycle();
      n++;
      if (cif.tc) break;
    end
    chk("presc.tc_latency", n, 2 * PRESC);
    cycle();
`endif

    // Randomized traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      int r;
      int lv;
      r  = int'($urandom_range(0, 9));
      lv = (r == 9) ? int'($urandom_range(1, 127)) : r;
      drive($urandom_range(0, 15) == 0, lv, $urandom_range(0, 3) != 0,
            1'($urandom_range(0, 1)), $urandom_range(0, 49) == 0);
      cycle();
      chk_model($sformatf("rnd%0d", k));
      chk($sformatf("rnd%0d.tc_ack_excl", k), int'(cif.tc && cif.load_ack), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
